// File: rtl/ball_mapper_pkg.sv
// rtl/ball_mapper_pkg.sv - shared types and constants for the ball screen mapper
package ball_mapper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_MULT   = 2'd2,
    ST_SUM    = 2'd3
  } state_t;

  localparam logic [15:0] Q8_ONE        = 16'h0100;
  localparam logic [15:0] DEG_FULL      = 16'd360;
  localparam int          LOOKUP_CYCLES = 2;

  // Turn a magnitude/sign pair (sign=1 means positive) into a signed 8.8 value
  function automatic logic signed [9:0] q88_signed(input logic [8:0] mag, input logic pos);
    logic signed [9:0] m;
    m = $signed({1'b0, mag});
    return pos ? m : -m;
  endfunction

endpackage

// File: rtl/ball_screen_mapper_cos_sin_lookup.sv
// rtl/ball_screen_mapper_cos_sin_lookup.sv - two-cycle cos/sin table, 8.8 magnitude plus sign
module cos_sin_lookup
  import ball_mapper_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic [8:0] angle_in,
  output logic [8:0] cos_mag,
  output logic       cos_pos,
  output logic [8:0] sin_mag,
  output logic       sin_pos
);

  // round(256*sin(k deg)) for k = 90 down to 0; entry k sits at bits [k*9 +: 9]
  localparam logic [91*9-1:0] SIN_TAB = {
    Q8_ONE[8:0], 9'd256, 9'd256, 9'd256, 9'd255, 9'd255, 9'd255, 9'd254, 9'd254, 9'd253,
    9'd252, 9'd251, 9'd250, 9'd249, 9'd248, 9'd247, 9'd246, 9'd245, 9'd243, 9'd242,
    9'd241, 9'd239, 9'd237, 9'd236, 9'd234, 9'd232, 9'd230, 9'd228, 9'd226, 9'd224,
    9'd222, 9'd219, 9'd217, 9'd215, 9'd212, 9'd210, 9'd207, 9'd204, 9'd202, 9'd199,
    9'd196, 9'd193, 9'd190, 9'd187, 9'd184, 9'd181, 9'd178, 9'd175, 9'd171, 9'd168,
    9'd165, 9'd161, 9'd158, 9'd154, 9'd150, 9'd147, 9'd143, 9'd139, 9'd136, 9'd132,
    9'd128, 9'd124, 9'd120, 9'd116, 9'd112, 9'd108, 9'd104, 9'd100, 9'd96,  9'd92,
    9'd88,  9'd83,  9'd79,  9'd75,  9'd71,  9'd66,  9'd62,  9'd58,  9'd53,  9'd49,
    9'd44,  9'd40,  9'd36,  9'd31,  9'd27,  9'd22,  9'd18,  9'd13,  9'd9,   9'd4,
    9'd0
  };

  logic [6:0] sin_idx_d, cos_idx_d, sin_idx_q, cos_idx_q;
  logic       sin_pos_d, cos_pos_d, sin_pos_q, cos_pos_q;

  // Fold the angle into the first quadrant; cos(a) is read as sin(90-a)
  always_comb begin
    sin_idx_d = '0;
    cos_idx_d = '0;
    sin_pos_d = 1'b1;
    cos_pos_d = 1'b1;
    if (angle_in < 9'd90) begin
      sin_idx_d = 7'(angle_in);
      cos_idx_d = 7'(9'd90 - angle_in);
    end else if (angle_in < 9'd180) begin
      sin_idx_d = 7'(9'd180 - angle_in);
      cos_idx_d = 7'(angle_in - 9'd90);
      cos_pos_d = 1'b0;
    end else if (angle_in < 9'd270) begin
      sin_idx_d = 7'(angle_in - 9'd180);
      cos_idx_d = 7'(9'd270 - angle_in);
      sin_pos_d = 1'b0;
      cos_pos_d = 1'b0;
    end else begin
      sin_idx_d = 7'(9'd360 - angle_in);
      cos_idx_d = 7'(angle_in - 9'd270);
      sin_pos_d = 1'b0;
    end
  end

  // First stage: register quadrant indices and signs
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sin_idx_q <= '0;
      cos_idx_q <= '0;
      sin_pos_q <= 1'b1;
      cos_pos_q <= 1'b1;
    end else begin
      sin_idx_q <= sin_idx_d;
      cos_idx_q <= cos_idx_d;
      sin_pos_q <= sin_pos_d;
      cos_pos_q <= cos_pos_d;
    end
  end

  // Second stage: register table reads
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sin_mag <= '0;
      cos_mag <= '0;
      sin_pos <= 1'b1;
      cos_pos <= 1'b1;
    end else begin
      sin_mag <= SIN_TAB[int'(sin_idx_q)*9 +: 9];
      cos_mag <= SIN_TAB[int'(cos_idx_q)*9 +: 9];
      sin_pos <= sin_pos_q;
      cos_pos <= cos_pos_q;
    end
  end

endmodule

// File: rtl/ball_screen_mapper.sv
// rtl/ball_screen_mapper.sv - map ball Q8.8 position and camera angle to screen pixels; BALL_MAPPER_CLAMP_EN saturates to screen edges
module ball_screen_mapper
  import ball_mapper_pkg::*;
#(
  parameter int PIVOT_X    = 80,
  parameter int PIVOT_Y    = 45,
  parameter int SCREEN_CX  = 640,
  parameter int SCREEN_CY  = 360,
  parameter int SCREEN_W   = 1280,
  parameter int SCREEN_H   = 720,
  parameter int ZOOM_SHIFT = 3
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               new_frame,
  input  logic [15:0]        ball_pos_x_in,
  input  logic [15:0]        ball_pos_y_in,
  input  logic [15:0]        cam_angle_in,
  output logic signed [11:0] screen_x,
  output logic signed [11:0] screen_y,
  output logic               on_screen,
  output logic               valid,
  output logic               busy,
  output logic               frame_dropped
);

  localparam logic signed [9:0]  PIVOT_X_S = 10'(PIVOT_X);
  localparam logic signed [9:0]  PIVOT_Y_S = 10'(PIVOT_Y);
  localparam logic signed [31:0] CX_S      = 32'(SCREEN_CX);
  localparam logic signed [31:0] CY_S      = 32'(SCREEN_CY);
  localparam logic signed [31:0] W_S       = 32'(SCREEN_W);
  localparam logic signed [31:0] H_S       = 32'(SCREEN_H);

  state_t             state, state_nx;
  logic [1:0]         lkp_cnt;
  logic               accept, drop, load_prod, load_out;
  logic [15:0]        angle_norm;
  logic [8:0]         angle_q;
  logic signed [9:0]  dx_q, dy_q;
  logic [8:0]         cos_mag, sin_mag;
  logic               cos_pos, sin_pos;
  logic signed [27:0] dx_ext, dy_ext, cos_ext, sin_ext;
  logic signed [27:0] p_dx_cos, p_dy_sin, p_dx_sin, p_dy_cos;
  logic signed [31:0] sum_x, sum_y, xr, yr, full_x, full_y;
  logic [11:0]        out_x, out_y;
  logic               on_screen_d;
  logic               unused_bits;

  // 360 degrees is the same view as 0
  assign angle_norm = (cam_angle_in >= DEG_FULL) ? cam_angle_in - DEG_FULL : cam_angle_in;

  // Sub-pixel fraction bits and the high angle bits do not affect the result
  assign unused_bits = ^{ball_pos_x_in[7:0], ball_pos_y_in[7:0], angle_norm[15:9]};

  cos_sin_lookup u_lookup (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .angle_in (angle_q),
    .cos_mag  (cos_mag),
    .cos_pos  (cos_pos),
    .sin_mag  (sin_mag),
    .sin_pos  (sin_pos)
  );

  assign dx_ext  = 28'(dx_q);
  assign dy_ext  = 28'(dy_q);
  assign cos_ext = 28'(q88_signed(cos_mag, cos_pos));
  assign sin_ext = 28'(q88_signed(sin_mag, sin_pos));

  // State register plus the dwell counter that waits out the lookup latency
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state   <= ST_IDLE;
      lkp_cnt <= '0;
    end else begin
      state   <= state_nx;
      lkp_cnt <= (state == ST_LOOKUP) ? lkp_cnt + 2'd1 : 2'd0;
    end
  end

  // Next-state: one conversion walks IDLE, LOOKUP x2, MULT, SUM
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (new_frame) state_nx = ST_LOOKUP;
      ST_LOOKUP: if (lkp_cnt == 2'(LOOKUP_CYCLES - 1)) state_nx = ST_MULT;
      ST_MULT:   state_nx = ST_SUM;
      ST_SUM:    state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Output decode: busy, datapath strobes, and detection of frames arriving while busy
  always_comb begin
    accept    = 1'b0;
    drop      = 1'b0;
    load_prod = 1'b0;
    load_out  = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE:   accept = new_frame;
      ST_LOOKUP: begin busy = 1'b1; drop = new_frame; end
      ST_MULT:   begin busy = 1'b1; drop = new_frame; load_prod = 1'b1; end
      ST_SUM:    begin busy = 1'b1; drop = new_frame; load_out  = 1'b1; end
      default:   busy = 1'b0;
    endcase
  end

  // Rotate, scale and offset from the registered products; visibility uses unclamped values
  always_comb begin
    sum_x       = 32'(p_dx_cos) + 32'(p_dy_sin);
    sum_y       = 32'(p_dy_cos) - 32'(p_dx_sin);
    xr          = sum_x >>> 8;
    yr          = sum_y >>> 8;
    full_x      = CX_S + (xr <<< ZOOM_SHIFT);
    full_y      = CY_S + (yr <<< ZOOM_SHIFT);
    on_screen_d = (full_x >= 0) && (full_x < W_S) && (full_y >= 0) && (full_y < H_S);
`ifdef BALL_MAPPER_CLAMP_EN
    if (full_x < 0)         out_x = '0;
    else if (full_x >= W_S) out_x = 12'(W_S - 1);
    else                    out_x = 12'(full_x);
    if (full_y < 0)         out_y = '0;
    else if (full_y >= H_S) out_y = 12'(H_S - 1);
    else                    out_y = 12'(full_y);
`else
    out_x = 12'(full_x);
    out_y = 12'(full_y);
`endif
  end

  // Capture frame inputs in IDLE and the four products in MULT
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      angle_q  <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      p_dx_cos <= '0;
      p_dy_sin <= '0;
      p_dx_sin <= '0;
      p_dy_cos <= '0;
    end else begin
      if (accept) begin
        angle_q <= angle_norm[8:0];
        dx_q    <= $signed({2'b00, ball_pos_x_in[15:8]}) - PIVOT_X_S;
        dy_q    <= $signed({2'b00, ball_pos_y_in[15:8]}) - PIVOT_Y_S;
      end
      if (load_prod) begin
        p_dx_cos <= dx_ext * cos_ext;
        p_dy_sin <= dy_ext * sin_ext;
        p_dx_sin <= dx_ext * sin_ext;
        p_dy_cos <= dy_ext * cos_ext;
      end
    end
  end

  // Result registers with the valid and frame_dropped pulses
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      screen_x      <= '0;
      screen_y      <= '0;
      on_screen     <= 1'b0;
      valid         <= 1'b0;
      frame_dropped <= 1'b0;
    end else begin
      valid         <= load_out;
      frame_dropped <= drop;
      if (load_out) begin
        screen_x  <= $signed(out_x);
        screen_y  <= $signed(out_y);
        on_screen <= on_screen_d;
      end
    end
  end

endmodule
